// File: rtl/row_fifo_bank_if.sv
// Handshake and data bundle between a raster pixel source, row_fifo_bank,
// and the downstream row read controller.
//   i_valid / i_data / o_ready : pixel write handshake (source -> bank)
//   i_read_enable              : per-row pop request (controller -> bank)
//   o_fifo_empty               : per-row empty flags (bank -> controller)
//   o_data                     : per-row last popped word, row r at r*DATA_W
//   o_trigger                  : one-cycle frame-complete pulse
// master = pixel source / controller side, slave = bank side.
interface row_fifo_bank_if #(
    parameter int ROW    = 9,
    parameter int DATA_W = 9
);
    logic                  i_valid;
    logic [DATA_W-1:0]     i_data;
    logic                  o_ready;
    logic [ROW-1:0]        i_read_enable;
    logic [ROW-1:0]        o_fifo_empty;
    logic [ROW*DATA_W-1:0] o_data;
    logic                  o_trigger;

    modport master (
        output i_valid, i_data, i_read_enable,
        input  o_ready, o_fifo_empty, o_data, o_trigger
    );

    modport slave (
        input  i_valid, i_data, i_read_enable,
        output o_ready, o_fifo_empty, o_data, o_trigger
    );
endinterface

// File: rtl/row_fifo_bank.sv
// Row FIFO bank: steers a raster pixel stream into ROW independent per-row
// FIFOs using a column/row counter, and lets the row read controller pop
// each FIFO independently. A registered pulse marks the last pixel of a
// frame.
// Ports:
//   i_clk    : clock, all logic on the rising edge
//   i_rst_n  : synchronous active-low reset
//   bus      : row_fifo_bank_if slave modport (write handshake, per-row
//              pop requests, empty flags, popped data, frame trigger)
module row_fifo_bank #(
    parameter int ROW    = 9,
    parameter int DATA_W = 9,
    parameter int COLS   = 9,
    parameter int DEPTH  = 16
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    row_fifo_bank_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROW > 1) ? $clog2(ROW) : 1;

    logic [DATA_W-1:0] mem      [ROW][DEPTH];
    logic [PTR_W-1:0]  wr_ptr   [ROW];
    logic [PTR_W-1:0]  rd_ptr   [ROW];
    logic [CNT_W-1:0]  count    [ROW];
    logic [DATA_W-1:0] rdata_p1 [ROW];
    logic [COL_W-1:0]  col_cnt;
    logic [ROW_W-1:0]  row_sel;
    logic              trig_p1;

    logic              ready;
    logic              accept;
    logic              last_col;
    logic              last_row;
    logic [ROW-1:0]    wr_en;
    logic [ROW-1:0]    pop;

    // Space is judged on the registered count only, so a same-cycle pop
    // never opens room for a same-cycle write.
    assign ready    = (count[row_sel] != CNT_W'(DEPTH));
    assign accept   = bus.i_valid && ready;
    assign last_col = (col_cnt == COL_W'(COLS - 1));
    assign last_row = (row_sel == ROW_W'(ROW - 1));

    always_comb begin
        wr_en = '0;
        pop   = '0;
        for (int r = 0; r < ROW; r++) begin
            wr_en[r] = accept && (row_sel == ROW_W'(r));
            pop[r]   = bus.i_read_enable[r] && (count[r] != '0);
        end
    end

    // ---- stage p0 -> p1: pointer/count update, popped word, trigger ----
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            col_cnt <= '0;
            row_sel <= '0;
            trig_p1 <= 1'b0;
            for (int r = 0; r < ROW; r++) begin
                wr_ptr[r]   <= '0;
                rd_ptr[r]   <= '0;
                count[r]    <= '0;
                rdata_p1[r] <= '0;
            end
        end else begin
            trig_p1 <= accept && last_col && last_row;
            if (accept) begin
                if (last_col) begin
                    col_cnt <= '0;
                    row_sel <= last_row ? '0 : row_sel + ROW_W'(1);
                end else begin
                    col_cnt <= col_cnt + COL_W'(1);
                end
            end
            for (int r = 0; r < ROW; r++) begin
                if (wr_en[r]) begin
                    wr_ptr[r] <= wr_ptr[r] + PTR_W'(1);
                end
                if (pop[r]) begin
                    rd_ptr[r]   <= rd_ptr[r] + PTR_W'(1);
                    rdata_p1[r] <= mem[r][rd_ptr[r]];
                end
                case ({wr_en[r], pop[r]})
                    2'b10:   count[r] <= count[r] + CNT_W'(1);
                    2'b01:   count[r] <= count[r] - CNT_W'(1);
                    default: count[r] <= count[r];
                endcase
            end
        end
    end

    // Storage carries no reset; reset pointers make stale words unreachable.
    always_ff @(posedge i_clk) begin
        for (int r = 0; r < ROW; r++) begin
            if (wr_en[r]) begin
                mem[r][wr_ptr[r]] <= bus.i_data;
            end
        end
    end

    always_comb begin
        bus.o_data       = '0;
        bus.o_fifo_empty = '0;
        for (int r = 0; r < ROW; r++) begin
            bus.o_data[r*DATA_W +: DATA_W] = rdata_p1[r];
            bus.o_fifo_empty[r]            = (count[r] == '0);
        end
    end

    assign bus.o_ready   = ready;
    assign bus.o_trigger = trig_p1;
endmodule

// File: tb/tb_row_fifo_bank.sv
module tb_row_fifo_bank;
    localparam int ROW    = 9;
    localparam int DATA_W = 9;
    localparam int COLS   = 9;
    localparam int DEPTH  = 16;

    typedef struct {
        int                row;
        logic [DATA_W-1:0] val;
    } sb_t;

    logic i_clk = 1'b0;
    logic i_rst_n;

    row_fifo_bank_if #(.ROW(ROW), .DATA_W(DATA_W)) bus ();

    row_fifo_bank #(.ROW(ROW), .DATA_W(DATA_W), .COLS(COLS), .DEPTH(DEPTH)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [DATA_W-1:0] mdl  [ROW][$];
    logic [DATA_W-1:0] mout [ROW];
    sb_t               sb_q [$];
    int                row_m;
    int                col_m;
    logic              trig_exp;
    int                trig_seen;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [ROW-1:0] exp_empty();
        logic [ROW-1:0] e;
        for (int r = 0; r < ROW; r++) e[r] = (mdl[r].size() == 0);
        return e;
    endfunction

    function automatic logic [ROW*DATA_W-1:0] exp_data();
        logic [ROW*DATA_W-1:0] d;
        for (int r = 0; r < ROW; r++) d[r*DATA_W +: DATA_W] = mout[r];
        return d;
    endfunction

    task automatic do_reset(input int n);
        i_rst_n           = 1'b0;
        bus.i_valid       = 1'b1;
        bus.i_data        = 9'h155;
        bus.i_read_enable = '1;
        repeat (n) @(posedge i_clk);
        #1;
        for (int r = 0; r < ROW; r++) begin
            mdl[r].delete();
            mout[r] = '0;
        end
        sb_q.delete();
        row_m = 0; col_m = 0; trig_exp = 1'b0; trig_seen = 0;
        chk("rst_empty", bus.o_fifo_empty, {ROW{1'b1}});
        chk("rst_data", bus.o_data, '0);
        chk("rst_trig", bus.o_trigger, 1'b0);
        chk("rst_ready", bus.o_ready, 1'b1);
        i_rst_n           = 1'b1;
        bus.i_valid       = 1'b0;
        bus.i_read_enable = '0;
    endtask

    // One clock: drive, predict, advance, compare.
    task automatic cycle(input logic v, input logic [DATA_W-1:0] d,
                         input logic [ROW-1:0] re, output logic acc);
        logic ready_m;
        bus.i_valid       = v;
        bus.i_data        = d;
        bus.i_read_enable = re;
        ready_m = (mdl[row_m].size() != DEPTH);
        chk("ready", bus.o_ready, ready_m);
        acc = v && ready_m;
        for (int r = 0; r < ROW; r++) begin
            if (re[r] && mdl[r].size() != 0) begin
                sb_t e;
                e.row = r;
                e.val = mdl[r].pop_front();
                mout[r] = e.val;
                sb_q.push_back(e);
            end
        end
        trig_exp = acc && (row_m == ROW - 1) && (col_m == COLS - 1);
        if (acc) begin
            mdl[row_m].push_back(d);
            if (col_m == COLS - 1) begin
                col_m = 0;
                row_m = (row_m == ROW - 1) ? 0 : row_m + 1;
            end else begin
                col_m++;
            end
        end
        @(posedge i_clk);
        #1;
        while (sb_q.size() != 0) begin
            sb_t e;
            e = sb_q.pop_front();
            chk($sformatf("pop_row%0d", e.row), bus.o_data[e.row*DATA_W +: DATA_W], e.val);
        end
        chk("trigger", bus.o_trigger, trig_exp);
        chk("empty", bus.o_fifo_empty, exp_empty());
        chk("data_hold", bus.o_data, exp_data());
        if (bus.o_trigger === 1'b1) trig_seen++;
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        logic acc;
        int   n;
        n = 0;
        do begin
            cycle(1'b1, d, '0, acc);
            n++;
        end while (!acc && n < 20);
        if (!acc) chk("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic pops(input logic [ROW-1:0] re, input int n);
        logic acc;
        repeat (n) cycle(1'b0, '0, re, acc);
    endtask

    initial begin
        logic acc;
        i_rst_n = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data = '0;
        bus.i_read_enable = '0;

        // Reset with traffic on the inputs
        do_reset(3);
        pops('0, 1);

        // Row fill then drain row 0 in order
        for (int i = 1; i <= COLS; i++) send(DATA_W'(i));
        chk("fill_empty", bus.o_fifo_empty, 9'h1FE);
        pops(9'h001, COLS);
        chk("drain_empty0", bus.o_fifo_empty[0], 1'b1);
        chk("drain_last", bus.o_data[DATA_W-1:0], 9'd9);

        // Full frame: single trigger, every row holds its pixels
        do_reset(1);
        for (int i = 0; i < ROW*COLS; i++) send(DATA_W'(i));
        chk("frame_trig_cnt", trig_seen, 1);
        pops('0, 2);
        chk("frame_trig_once", trig_seen, 1);
        pops({ROW{1'b1}}, COLS);
        chk("frame_drained", bus.o_fifo_empty, {ROW{1'b1}});

        // Backpressure: row 0 fills on the 7th pixel of frame 2
        do_reset(1);
        for (int i = 0; i < ROW*COLS + 7; i++) send(DATA_W'(i));
        chk("bp_ready_low", bus.o_ready, 1'b0);
        cycle(1'b1, DATA_W'(88), '0, acc);
        chk("bp_stall", acc, 1'b0);
        cycle(1'b1, DATA_W'(88), 9'h001, acc);
        chk("bp_ready_back", bus.o_ready, 1'b1);
        send(DATA_W'(88));
        pops(9'h001, DEPTH);
        chk("bp_last_word", bus.o_data[DATA_W-1:0], 9'd88);

        // Empty pop on row 3 leaves its slice unchanged
        do_reset(1);
        for (int i = 0; i < 4*COLS; i++) send(DATA_W'(i));
        pops(9'h008, COLS);
        pops(9'h008, 2);
        chk("row3_hold", bus.o_data[3*DATA_W +: DATA_W], 9'd35);

        // Simultaneous write and pop on row 0 with 4 entries
        do_reset(1);
        for (int i = 10; i < 14; i++) send(DATA_W'(i));
        cycle(1'b1, DATA_W'(14), 9'h001, acc);
        chk("simul_acc", acc, 1'b1);
        chk("simul_oldest", bus.o_data[DATA_W-1:0], 9'd10);
        pops(9'h001, 4);
        chk("simul_count4", bus.o_fifo_empty[0], 1'b1);
        chk("simul_tail", bus.o_data[DATA_W-1:0], 9'd14);

        // Mid-frame reset restarts at row 0, column 0
        do_reset(1);
        for (int i = 0; i < 40; i++) send(DATA_W'(i));
        do_reset(1);
        send(DATA_W'(200));
        chk("midrst_row0", bus.o_fifo_empty, 9'h1FE);
        for (int i = 1; i < ROW*COLS - 1; i++) send(DATA_W'(i));
        chk("midrst_no_trig", trig_seen, 0);
        send(DATA_W'(300));
        chk("midrst_trig", trig_seen, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
